// File: rtl/cdc_bus_arbiter.sv
// cdc_bus_arbiter
//   Shares one external cdc_handshake channel between NUM_CH quasi-static buses
//   (config/status registers) in the src_clk domain. A channel is dirty when its
//   value differs from the last value delivered. Dirty channels are granted one
//   at a time, and {index, data} goes out through the handshake.
//
// Configuration macro:
//   CDC_ARB_FIXED_PRIO_EN  defined   -> the lowest-index dirty channel wins and
//                                       there is no round-robin pointer
//                                       (channel 0 can starve the others)
//                          undefined -> round-robin starting at rr_ptr (default)
//
// Ports:
//   rst        in   async reset, active-high
//   src_clk    in   clock; all logic is in this domain
//   ch_data    in   channel i = ch_data[i*WIDTH +: WIDTH]
//   ch_synced  out  1 = channel i was delivered and has not changed since
//   hs_data    out  {idx, data} to the handshake src port; stable through WAIT
//   hs_val     out  one-cycle request pulse to the handshake
//   hs_ack     in   one-cycle completion pulse from the handshake
//   busy       out  1 while a transfer is in flight (state != IDLE)
module cdc_bus_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned IDX_W  = 2
) (
  input  logic                    rst,
  input  logic                    src_clk,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]       ch_synced,
  output logic [IDX_W+WIDTH-1:0]  hs_data,
  output logic                    hs_val,
  input  logic                    hs_ack,
  output logic                    busy
);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait
  } state_e;

  state_e                 state_q;
  logic [WIDTH-1:0]       ch_val [NUM_CH];
  logic [WIDTH-1:0]       prev_q [NUM_CH];
  logic [NUM_CH-1:0]      dirty;
  logic                   any_dirty;
  logic [IDX_W-1:0]       sel;
  logic [IDX_W-1:0]       sel_q;
  logic [WIDTH-1:0]       sel_data;
  logic [IDX_W+WIDTH-1:0] hs_data_q;
  logic                   hs_val_q;
  logic                   busy_q;

`ifndef CDC_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]       rr_ptr_q;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_val[i]    = ch_data[i*WIDTH +: WIDTH];
    assign dirty[i]     = (ch_val[i] != prev_q[i]);
    // The channel in flight is not synced yet even if its value already matches.
    assign ch_synced[i] = !dirty[i] && !(busy_q && (sel_q == IDX_W'(i)));
  end

  // Grant selection. Loop indices are constants after unrolling, so every
  // select below stays in range and indices >= NUM_CH can never be produced.
  always_comb begin
    sel       = '0;
    sel_data  = '0;
    any_dirty = 1'b0;
`ifndef CDC_ARB_FIXED_PRIO_EN
    // First pass: channels at or after rr_ptr.
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any_dirty && dirty[i] && (i >= int'(rr_ptr_q))) begin
        any_dirty = 1'b1;
        sel       = IDX_W'(i);
        sel_data  = ch_val[i];
      end
    end
`endif
    // Lowest-index dirty channel: the wrap-around pass for round-robin,
    // or the only pass in fixed-priority mode.
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any_dirty && dirty[i]) begin
        any_dirty = 1'b1;
        sel       = IDX_W'(i);
        sel_data  = ch_val[i];
      end
    end
  end

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      hs_val_q  <= 1'b0;
      busy_q    <= 1'b0;
      hs_data_q <= '0;
      sel_q     <= '0;
`ifndef CDC_ARB_FIXED_PRIO_EN
      rr_ptr_q  <= '0;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        prev_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_dirty) begin
            // Snapshot taken once; later changes are picked up by a new grant.
            hs_data_q <= {sel, sel_data};
            sel_q     <= sel;
            hs_val_q  <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StSend;
          end
        end
        StSend: begin
          hs_val_q <= 1'b0;
          state_q  <= StWait;
        end
        StWait: begin
          if (hs_ack) begin
            // prev takes the delivered snapshot, not the live value.
            for (int i = 0; i < NUM_CH; i++) begin
              if (sel_q == IDX_W'(i)) begin
                prev_q[i] <= hs_data_q[WIDTH-1:0];
              end
            end
`ifndef CDC_ARB_FIXED_PRIO_EN
            rr_ptr_q <= (32'(sel_q) == NUM_CH - 1) ? '0 : sel_q + 1'b1;
`endif
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: begin
          hs_val_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign hs_data = hs_data_q;
  assign hs_val  = hs_val_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_cdc_bus_arbiter.sv
module tb_cdc_bus_arbiter;

  logic        rst;
  logic        src_clk;
  logic [31:0] ch_data;
  logic [3:0]  ch_synced;
  logic [9:0]  hs_data;
  logic        hs_val;
  logic        hs_ack;
  logic        busy;

  int total = 0;
  int bad   = 0;

  cdc_bus_arbiter #(
    .NUM_CH(4),
    .WIDTH (8),
    .IDX_W (2)
  ) dut (
    .rst      (rst),
    .src_clk  (src_clk),
    .ch_data  (ch_data),
    .ch_synced(ch_synced),
    .hs_data  (hs_data),
    .hs_val   (hs_val),
    .hs_ack   (hs_ack),
    .busy     (busy)
  );

  initial begin
    src_clk = 1'b0;
    forever #5 src_clk = ~src_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] ch;
    logic        ack;
    logic [3:0]  syn;
    logic        val;
    logic        bsy;
    logic [9:0]  hsd;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Resets with all channels zero, checks the reset outputs.
  task automatic do_reset();
    @(negedge src_clk);
    rst     = 1'b1;
    ch_data = '0;
    hs_ack  = 1'b0;
    #1;
    chk("rst_synced", 32'(ch_synced), 32'hF);
    chk("rst_val", 32'(hs_val), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_hsdata", 32'(hs_data), 32'h0);
    @(negedge src_clk);
    rst = 1'b0;
  endtask

  // Returns at negedge+1 of the SEND cycle, or flags a timeout.
  task automatic wait_val(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge src_clk);
      #1;
      if (hs_val === 1'b1) seen = 1'b1;
    end
    chk({name, "_val_timeout"}, 32'(seen), 32'h1);
  endtask

  // Called from the SEND cycle; pulses hs_ack n cycles later (n >= 1 lands in WAIT).
  task automatic ack_after(input int n);
    repeat (n) @(negedge src_clk);
    hs_ack = 1'b1;
    @(negedge src_clk);
    hs_ack = 1'b0;
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    ch_data = '0;
    hs_ack  = 1'b0;
    repeat (2) @(negedge src_clk);
    do_reset();

    // All zero: no pulse ever.
    for (int i = 0; i < 5; i++) begin
      @(negedge src_clk);
      #1;
      chk("idle_no_val", 32'(hs_val), 32'h0);
    end

    // ch2=A5, ack 4 cycles after hs_val, then spurious acks while idle.
    tbl[0]  = '{32'h0000_0000, 1'b0, 4'hF,    1'b0, 1'b0, 10'h000};
    tbl[1]  = '{32'h00A5_0000, 1'b0, 4'b1011, 1'b0, 1'b0, 10'h000};
    tbl[2]  = '{32'h00A5_0000, 1'b0, 4'b1011, 1'b1, 1'b1, 10'h2A5};
    tbl[3]  = '{32'h00A5_0000, 1'b0, 4'b1011, 1'b0, 1'b1, 10'h2A5};
    tbl[4]  = '{32'h00A5_0000, 1'b0, 4'b1011, 1'b0, 1'b1, 10'h2A5};
    tbl[5]  = '{32'h00A5_0000, 1'b0, 4'b1011, 1'b0, 1'b1, 10'h2A5};
    tbl[6]  = '{32'h00A5_0000, 1'b1, 4'b1011, 1'b0, 1'b1, 10'h2A5};
    tbl[7]  = '{32'h00A5_0000, 1'b0, 4'hF,    1'b0, 1'b0, 10'h2A5};
    tbl[8]  = '{32'h00A5_0000, 1'b0, 4'hF,    1'b0, 1'b0, 10'h2A5};
    tbl[9]  = '{32'h00A5_0000, 1'b1, 4'hF,    1'b0, 1'b0, 10'h2A5};
    tbl[10] = '{32'h00A5_0000, 1'b0, 4'hF,    1'b0, 1'b0, 10'h2A5};
    for (int i = 0; i < 11; i++) begin
      @(negedge src_clk);
      ch_data = tbl[i].ch;
      hs_ack  = tbl[i].ack;
      #1;
      chk($sformatf("vec%0d_synced", i), 32'(ch_synced), 32'(tbl[i].syn));
      chk($sformatf("vec%0d_val", i), 32'(hs_val), 32'(tbl[i].val));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("vec%0d_hsdata", i), 32'(hs_data), 32'(tbl[i].hsd));
    end
    hs_ack = 1'b0;

    // rr_ptr is 3 now: ch0 and ch3 dirty -> ch3 first, then wrap to ch0.
    @(negedge src_clk);
    ch_data = 32'h03A5_0001;
    wait_val("rr3");
    chk("rr3_hsdata", 32'(hs_data), 32'h303);
    ack_after(2);
    wait_val("rr0");
    chk("rr0_hsdata", 32'(hs_data), 32'h001);
    ack_after(1);
    chk("rr_done_synced", 32'(ch_synced), 32'hF);

    // All four change together from reset: grants 0,1,2,3.
    do_reset();
    @(negedge src_clk);
    ch_data = 32'h4433_2211;
    for (int c = 0; c < 4; c++) begin
      logic [9:0] exp_hs;
      exp_hs = {c[1:0], 8'((c + 1) * 8'h11)};
      wait_val($sformatf("all%0d", c));
      chk($sformatf("all%0d_hsdata", c), 32'(hs_data), 32'(exp_hs));
      ack_after(2);
    end
    chk("all_synced", 32'(ch_synced), 32'hF);
    chk("all_busy", 32'(busy), 32'h0);

    // Snapshot: ch1 changes 11 -> 22 while the first transfer waits.
    do_reset();
    @(negedge src_clk);
    ch_data = 32'h0000_1100;
    wait_val("snap1");
    chk("snap1_hsdata", 32'(hs_data), 32'h111);
    @(negedge src_clk);
    ch_data = 32'h0000_2200;
    #1;
    chk("snap_wait_hsdata", 32'(hs_data), 32'h111);
    chk("snap_wait_synced", 32'(ch_synced), 32'b1101);
    hs_ack = 1'b1;
    @(negedge src_clk);
    hs_ack = 1'b0;
    #1;
    chk("snap_after_ack_synced", 32'(ch_synced), 32'b1101);
    chk("snap_after_ack_busy", 32'(busy), 32'h0);
    wait_val("snap2");
    chk("snap2_hsdata", 32'(hs_data), 32'h122);
    ack_after(3);
    chk("snap_done_synced", 32'(ch_synced), 32'hF);

    // Reset during WAIT with ch3=7F, then the channel is resent.
    do_reset();
    @(negedge src_clk);
    ch_data = 32'h7F00_0000;
    wait_val("rw1");
    chk("rw1_hsdata", 32'(hs_data), 32'h37F);
    @(negedge src_clk);
    rst = 1'b1;
    #1;
    chk("rw_rst_val", 32'(hs_val), 32'h0);
    chk("rw_rst_busy", 32'(busy), 32'h0);
    chk("rw_rst_hsdata", 32'(hs_data), 32'h0);
    chk("rw_rst_synced", 32'(ch_synced), 32'b0111);
    @(negedge src_clk);
    rst = 1'b0;
    wait_val("rw2");
    chk("rw2_hsdata", 32'(hs_data), 32'h37F);
    ack_after(1);
    chk("rw_done_synced", 32'(ch_synced), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
